// File: rtl/aes_job_sequencer.sv
// aes_job_sequencer: ring-buffered job issuer and in-order result checker for aes_engine.
// Host jobs are presented under the engine load handshake; returned results are scored against expectations.
module aes_job_sequencer #(
    parameter int DATA_W  = 128,
    parameter int DEPTH   = 16,
    parameter int MAX_OUT = 8,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              host_wr_valid,
    output logic              host_wr_ready,
    input  logic [DATA_W-1:0] host_wr_data,
    input  logic [DATA_W-1:0] host_wr_exp,
    input  logic              host_wr_en_de,
    input  logic              host_wr_setkey,
    input  logic              start,
    input  logic              clear,
    output logic              eng_valid,
    output logic [DATA_W-1:0] eng_data,
    output logic              eng_en_de,
    output logic              eng_set_key,
    input  logic              eng_load,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    input  logic              res_en_de,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [CNT_W-1:0]  max_lat
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(MAX_OUT);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2, ST_ERR = 2'd3} state_t;
    state_t state_r, state_next_s;

    logic [DATA_W-1:0]  ring_data_r [DEPTH];
    logic [DATA_W-1:0]  ring_exp_r  [DEPTH];
    logic [DEPTH-1:0]   ring_en_de_r, ring_key_r;
    logic [AW:0]        ring_wr_ptr_r, ring_rd_ptr_r;
    logic [DATA_W-1:0]  sb_exp_r   [MAX_OUT];
    logic [CNT_W-1:0]   sb_stamp_r [MAX_OUT];
    logic [MAX_OUT-1:0] sb_en_de_r;
    logic [SW-1:0]      sb_wr_ptr_r, sb_rd_ptr_r;
    logic [SW:0]        sb_cnt_r, sb_cnt_next_s;
    logic [DATA_W-1:0]  eng_exp_r;
    logic [CNT_W-1:0]   stamp_r;
    logic [TW-1:0]      to_cnt_r;

    logic              ring_empty_s, ring_full_s, wr_en_s, run_s, accept_s, push_s, pop_s;
    logic              sb_empty_s, stray_s, timeout_s, err_s, issue_s, match_s, cmp_en_de_s;
    logic [AW-1:0]     head_idx_s;
    logic [DATA_W-1:0] cmp_exp_s;
    logic [CNT_W-1:0]  cmp_stamp_s, lat_s;

    assign ring_empty_s  = (ring_wr_ptr_r == ring_rd_ptr_r);
    assign ring_full_s   = (ring_wr_ptr_r[AW] != ring_rd_ptr_r[AW]) &&
                           (ring_wr_ptr_r[AW-1:0] == ring_rd_ptr_r[AW-1:0]);
    assign host_wr_ready = !ring_full_s && (state_r != ST_ERR);
    assign wr_en_s       = host_wr_valid && host_wr_ready && !clear;
    assign head_idx_s    = ring_rd_ptr_r[AW-1:0];
    assign run_s         = (state_r == ST_RUN);
    assign accept_s      = run_s && eng_valid && eng_load;
    assign push_s        = accept_s && !eng_set_key;
    assign sb_empty_s    = (sb_cnt_r == '0);
    assign pop_s         = run_s && res_valid && (!sb_empty_s || push_s);
    assign stray_s       = run_s && res_valid && sb_empty_s && !push_s;
    assign timeout_s     = run_s && !res_valid && !sb_empty_s && (to_cnt_r == TW'(TIMEOUT - 1));
    assign err_s         = stray_s || timeout_s;
    // Key jobs bypass the outstanding limit since they never produce a result.
    assign issue_s       = run_s && !err_s && (!eng_valid || accept_s) && !ring_empty_s &&
                           (ring_key_r[head_idx_s] || (sb_cnt_next_s < (SW+1)'(MAX_OUT)));
    assign match_s       = (res_data == cmp_exp_s) && (res_en_de == cmp_en_de_s);
    assign lat_s         = stamp_r - cmp_stamp_s;
    assign busy          = (state_r == ST_RUN);
    assign done          = (state_r == ST_DONE);
    assign error         = (state_r == ST_ERR);

    // Oldest scoreboard entry; an empty scoreboard compares against the job being pushed now.
    always_comb begin
        cmp_exp_s   = sb_exp_r[sb_rd_ptr_r];
        cmp_en_de_s = sb_en_de_r[sb_rd_ptr_r];
        cmp_stamp_s = sb_stamp_r[sb_rd_ptr_r];
        if (sb_empty_s) begin
            cmp_exp_s   = eng_exp_r;
            cmp_en_de_s = eng_en_de;
            cmp_stamp_s = stamp_r;
        end else begin
            cmp_exp_s   = sb_exp_r[sb_rd_ptr_r];
        end
    end

    // Scoreboard occupancy after this cycle's push/pop.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   sb_cnt_next_s = sb_cnt_r + (SW+1)'(1);
            2'b01:   sb_cnt_next_s = sb_cnt_r - (SW+1)'(1);
            default: sb_cnt_next_s = sb_cnt_r;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        if (clear) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start && !ring_empty_s) state_next_s = ST_RUN;
                    else                        state_next_s = state_r;
                end
                ST_RUN: begin
                    if (err_s)                                         state_next_s = ST_ERR;
                    else if (ring_empty_s && sb_empty_s && !eng_valid) state_next_s = ST_DONE;
                    else                                               state_next_s = ST_RUN;
                end
                ST_ERR:  state_next_s = ST_ERR;
                default: state_next_s = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= state_next_s;
    end

    // Ring and scoreboard storage.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            ring_data_r[ring_wr_ptr_r[AW-1:0]]  <= host_wr_data;
            ring_exp_r[ring_wr_ptr_r[AW-1:0]]   <= host_wr_exp;
            ring_en_de_r[ring_wr_ptr_r[AW-1:0]] <= host_wr_en_de;
            ring_key_r[ring_wr_ptr_r[AW-1:0]]   <= host_wr_setkey;
        end
        if (push_s && !clear) begin
            sb_exp_r[sb_wr_ptr_r]   <= eng_exp_r;
            sb_en_de_r[sb_wr_ptr_r] <= eng_en_de;
            sb_stamp_r[sb_wr_ptr_r] <= stamp_r;
        end
    end

    // Ring and scoreboard pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ring_wr_ptr_r <= '0;
            ring_rd_ptr_r <= '0;
            sb_wr_ptr_r   <= '0;
            sb_rd_ptr_r   <= '0;
            sb_cnt_r      <= '0;
        end else if (clear) begin
            ring_wr_ptr_r <= '0;
            ring_rd_ptr_r <= '0;
            sb_wr_ptr_r   <= '0;
            sb_rd_ptr_r   <= '0;
            sb_cnt_r      <= '0;
        end else begin
            if (wr_en_s) ring_wr_ptr_r <= ring_wr_ptr_r + (AW+1)'(1);
            if (issue_s) ring_rd_ptr_r <= ring_rd_ptr_r + (AW+1)'(1);
            if (push_s)  sb_wr_ptr_r   <= sb_wr_ptr_r + SW'(1);
            if (pop_s)   sb_rd_ptr_r   <= sb_rd_ptr_r + SW'(1);
            sb_cnt_r <= sb_cnt_next_s;
        end
    end

    // Engine-facing job register; held while the engine withholds load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_valid   <= 1'b0;
            eng_data    <= '0;
            eng_en_de   <= 1'b0;
            eng_set_key <= 1'b0;
            eng_exp_r   <= '0;
        end else if (clear) begin
            eng_valid   <= 1'b0;
            eng_data    <= '0;
            eng_en_de   <= 1'b0;
            eng_set_key <= 1'b0;
            eng_exp_r   <= '0;
        end else if (err_s) begin
            eng_valid   <= 1'b0;
        end else if (issue_s) begin
            eng_valid   <= 1'b1;
            eng_data    <= ring_data_r[head_idx_s];
            eng_en_de   <= ring_en_de_r[head_idx_s];
            eng_set_key <= ring_key_r[head_idx_s];
            eng_exp_r   <= ring_exp_r[head_idx_s];
        end else if (accept_s) begin
            eng_valid   <= 1'b0;
        end else begin
            eng_valid   <= eng_valid;
        end
    end

    // Free-running stamp and result watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stamp_r  <= '0;
            to_cnt_r <= '0;
        end else if (clear) begin
            stamp_r  <= '0;
            to_cnt_r <= '0;
        end else begin
            stamp_r <= stamp_r + CNT_W'(1);
            if (!run_s || res_valid || sb_empty_s) to_cnt_r <= '0;
            else                                   to_cnt_r <= to_cnt_r + TW'(1);
        end
    end

    // Saturating result statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
            max_lat  <= '0;
        end else if (clear) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
            max_lat  <= '0;
        end else if (pop_s) begin
            if (match_s && (pass_cnt != '1))       pass_cnt <= pass_cnt + CNT_W'(1);
            else if (!match_s && (fail_cnt != '1)) fail_cnt <= fail_cnt + CNT_W'(1);
            else                                   pass_cnt <= pass_cnt;
            if (lat_s > max_lat) max_lat <= lat_s;
        end else begin
            max_lat <= max_lat;
        end
    end
endmodule

// File: tb/tb_aes_job_sequencer.sv
// Randomized bench for aes_job_sequencer with a behavioural engine and a job-level reference model.
module tb_aes_job_sequencer;
    localparam int DATA_W = 128, DEPTH = 16, MAX_OUT = 8, CNT_W = 16, TIMEOUT = 1024;
    localparam logic [127:0] K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0, rst_n = 1'b0;
    logic host_wr_valid = 1'b0, host_wr_ready, host_wr_en_de = 1'b0, host_wr_setkey = 1'b0;
    logic [DATA_W-1:0] host_wr_data = '0, host_wr_exp = '0, eng_data, res_data = '0;
    logic start = 1'b0, clear = 1'b0, eng_valid, eng_en_de, eng_set_key, eng_load = 1'b0;
    logic res_valid = 1'b0, res_en_de = 1'b0, busy, done, error;
    logic [CNT_W-1:0] pass_cnt, fail_cnt, max_lat;

    always #5 clk = ~clk;

    aes_job_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .CNT_W(CNT_W),
                        .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
        .host_wr_data(host_wr_data), .host_wr_exp(host_wr_exp), .host_wr_en_de(host_wr_en_de),
        .host_wr_setkey(host_wr_setkey), .start(start), .clear(clear), .eng_valid(eng_valid),
        .eng_data(eng_data), .eng_en_de(eng_en_de), .eng_set_key(eng_set_key), .eng_load(eng_load),
        .res_valid(res_valid), .res_data(res_data), .res_en_de(res_en_de), .busy(busy), .done(done),
        .error(error), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .max_lat(max_lat));

    typedef struct { logic [127:0] data; logic [127:0] exp; logic en_de; logic key; } job_t;
    typedef struct { logic [127:0] res; logic res_en_de; logic [127:0] exp; logic exp_en_de;
                     int acc_cyc; int due; } flight_t;

    job_t    job_q[$];
    flight_t pipe[$];
    job_t    cur_job;
    bit      have_cur = 1'b0, m_err = 1'b0;
    logic [127:0] eng_key = '0, wr_key = K;
    int cyc = 0, n_acc = 0, load_pct = 100, res_allow = -1, flip_pct = 0;
    int exp_pass = 0, exp_fail = 0, exp_max = 0;
    int tests_run = 0, tests_failed = 0;

    // Stand-in engine: the known AES-128 vector for the test key, a keyed scramble otherwise.
    function automatic logic [127:0] eng_fn(input logic [127:0] key, input logic [127:0] data,
                                            input logic en_de);
        if (key == K && data == P && en_de) return C;
        return data ^ key ^ {128{en_de}};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // One engine cycle: return due results, present load, track the presented job.
    task automatic step();
        flight_t f;
        int lat;
        @(negedge clk);
        res_valid = 1'b0;
        if (res_allow != 0 && pipe.size() > 0 && pipe[0].due <= cyc) begin
            f = pipe.pop_front();
            res_valid = 1'b1;
            res_data  = f.res;
            res_en_de = f.res_en_de;
            if (f.res == f.exp && f.res_en_de == f.exp_en_de) exp_pass++;
            else                                              exp_fail++;
            lat = cyc - f.acc_cyc;
            if (lat > exp_max) exp_max = lat;
            if (res_allow > 0) res_allow--;
        end
        eng_load = (int'($urandom_range(99)) < load_pct);
        if (eng_valid && !have_cur) begin
            check_val("issue_pending", 128'(job_q.size() != 0), 128'd1);
            if (job_q.size() != 0) begin
                cur_job  = job_q.pop_front();
                have_cur = 1'b1;
            end
        end
        if (eng_valid && have_cur) begin
            check_val("eng_data", eng_data, cur_job.data);
            check_val("eng_ctl", {126'd0, eng_en_de, eng_set_key}, {126'd0, cur_job.en_de, cur_job.key});
            if (eng_load) begin
                n_acc++;
                have_cur = 1'b0;
                if (cur_job.key) begin
                    eng_key = cur_job.data;
                end else begin
                    f.res       = eng_fn(eng_key, cur_job.data, cur_job.en_de);
                    f.res_en_de = cur_job.en_de ^ (int'($urandom_range(99)) < flip_pct);
                    f.exp       = cur_job.exp;
                    f.exp_en_de = cur_job.en_de;
                    f.acc_cyc   = cyc;
                    f.due       = cyc + 1 + int'($urandom_range(5));
                    pipe.push_back(f);
                end
            end
        end
        tick();
    endtask

    task automatic write_job(input logic [127:0] data, input logic [127:0] exp, input logic en_de,
                             input logic key);
        bit want;
        want = (job_q.size() < DEPTH) && !m_err;
        @(negedge clk);
        res_valid = 1'b0;
        eng_load  = 1'b0;
        host_wr_valid = 1'b1; host_wr_data = data; host_wr_exp = exp;
        host_wr_en_de = en_de; host_wr_setkey = key;
        check_val("wr_ready", 128'(host_wr_ready), 128'(want));
        tick();
        host_wr_valid = 1'b0;
        if (want) job_q.push_back('{data: data, exp: exp, en_de: en_de, key: key});
        if (want && key) wr_key = data;
    endtask

    // Data job whose expectation is correct unless a random bit is corrupted.
    task automatic write_rand_job(input int bad_pct);
        logic [127:0] d, e, flip;
        logic ed;
        d = rnd128();
        ed = 1'($urandom_range(1));
        e = eng_fn(wr_key, d, ed);
        flip = 128'd1 << $urandom_range(127);
        if (int'($urandom_range(99)) < bad_pct) e = e ^ flip;
        write_job(d, e, ed, 1'b0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        res_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        res_valid = 1'b0;
        eng_load  = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        job_q.delete(); pipe.delete();
        have_cur = 1'b0; m_err = 1'b0;
        exp_pass = 0; exp_fail = 0; exp_max = 0; n_acc = 0;
        res_allow = -1; flip_pct = 0; load_pct = 100;
        wr_key = eng_key;
    endtask

    task automatic run_done(input string tag, input int budget);
        for (int k = 0; k < budget; k++) begin
            step();
            if (done && pipe.size() == 0) break;
        end
        res_valid = 1'b0;
        eng_load  = 1'b0;
        check_val({tag, "_done"}, 128'(done), 128'd1);
        check_val({tag, "_pass"}, 128'(pass_cnt), 128'(exp_pass));
        check_val({tag, "_fail"}, 128'(fail_cnt), 128'(exp_fail));
        check_val({tag, "_maxlat"}, 128'(max_lat), 128'(exp_max));
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_flags"}, {125'd0, busy, done, error}, 128'd0);
        check_val({tag, "_cnts"}, {80'd0, pass_cnt, fail_cnt, max_lat}, 128'd0);
        check_val({tag, "_eng_valid"}, 128'(eng_valid), 128'd0);
        check_val({tag, "_ready"}, 128'(host_wr_ready), 128'd1);
    endtask

    initial begin
        repeat (3) tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_idle("reset");

        // Known-answer job passes.
        write_job(K, '0, 1'b1, 1'b1);
        write_job(P, C, 1'b1, 1'b0);
        pulse_start();
        run_done("kat", 200);
        check_val("kat_pass1", 128'(pass_cnt), 128'd1);

        // Same job, expectation corrupted in bit 0.
        do_clear();
        write_job(K, '0, 1'b1, 1'b1);
        write_job(P, C ^ 128'd1, 1'b1, 1'b0);
        pulse_start();
        run_done("kat_bad", 200);
        check_val("kat_bad_fail1", 128'(fail_cnt), 128'd1);

        // Full ring, 17th write refused, then drain.
        do_clear();
        write_job(K, '0, 1'b1, 1'b1);
        for (int i = 0; i < 15; i++) write_rand_job(30);
        write_rand_job(0);
        pulse_start();
        load_pct = 70;
        run_done("full", 2000);
        check_val("full_issued", 128'(n_acc), 128'd16);

        // Engine withholds load; presented job must hold.
        do_clear();
        write_job(K, '0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) write_rand_job(0);
        load_pct = 0;
        pulse_start();
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            check_val("hold_valid", 128'(eng_valid), 128'd1);
        end
        check_val("hold_no_issue", 128'(n_acc), 128'd0);
        load_pct = 100;
        run_done("hold", 500);
        check_val("hold_issued", 128'(n_acc), 128'd4);

        // Outstanding limit with results withheld, then 1:1 release.
        do_clear();
        write_job(K, '0, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) write_rand_job(0);
        res_allow = 0;
        pulse_start();
        repeat (30) step();
        check_val("maxout_stall", 128'(n_acc), 128'(1 + MAX_OUT));
        for (int k = 0; k < 3; k++) begin
            res_allow = 1;
            repeat (6) step();
            check_val("maxout_release", 128'(n_acc), 128'(2 + MAX_OUT + k));
        end
        res_allow = -1;
        run_done("maxout", 1000);
        check_val("maxout_issued", 128'(n_acc), 128'd13);

        // Result timeout.
        do_clear();
        write_rand_job(0);
        res_allow = 0;
        pulse_start();
        repeat (900) step();
        check_val("to_early", 128'(error), 128'd0);
        repeat (200) step();
        check_val("to_error", 128'(error), 128'd1);
        check_val("to_eng_valid", 128'(eng_valid), 128'd0);
        check_val("to_cnts", {96'd0, pass_cnt, fail_cnt}, 128'd0);
        m_err = 1'b1;
        write_rand_job(0);
        do_clear();
        check_idle("to_clear");

        // Stray result with an empty scoreboard.
        write_job(K, '0, 1'b1, 1'b1);
        write_rand_job(0);
        load_pct = 0;
        pulse_start();
        repeat (3) step();
        @(negedge clk);
        eng_load = 1'b0;
        res_valid = 1'b1; res_data = rnd128(); res_en_de = 1'b1;
        tick();
        res_valid = 1'b0;
        check_val("stray_error", 128'(error), 128'd1);
        check_val("stray_eng_valid", 128'(eng_valid), 128'd0);
        check_val("stray_cnts", {96'd0, pass_cnt, fail_cnt}, 128'd0);
        do_clear();
        check_idle("stray_clear");

        // Random batches restarted from DONE without clearing.
        for (int r = 0; r < 4; r++) begin
            int n;
            n = int'($urandom_range(1, DEPTH));
            for (int i = 0; i < n; i++) begin
                if (int'($urandom_range(9)) == 0) write_job(rnd128(), '0, 1'($urandom_range(1)), 1'b1);
                else                              write_rand_job(25);
            end
            load_pct = int'($urandom_range(30, 100));
            flip_pct = 5;
            pulse_start();
            run_done("rand", 3000);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
